// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : sequences one or two tagged frames per job into the TX bridge
// Revision 1.0
// ============================================================================
module uart_tx_scheduler #(
  parameter int MESSAGE_SIZE = 512,
  parameter int HEADER_SIZE  = 32,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ext_tx_valid_in,
  output logic                    ext_tx_ready_out,
  input  logic [MESSAGE_SIZE-1:0] tx_encrypted_in,
  input  logic [MESSAGE_SIZE-1:0] tx_decrypted_in,
  input  logic [HEADER_SIZE-1:0]  tx_header_in,
  input  logic [1:0]              tx_mode_in,
  output logic [MESSAGE_SIZE-1:0] bdge_message_out,
  output logic [HEADER_SIZE-1:0]  bdge_header_out,
  output logic                    bdge_valid_out,
  input  logic                    bdge_ready_in,
  output logic                    mode_err_out,
  output logic [15:0]             frames_sent_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_SECOND = 2'd3;

  localparam logic [1:0] C_MODE_MIXED = 2'b00;
  localparam logic [1:0] C_MODE_ENC   = 2'b10;
  localparam logic [1:0] C_MODE_BAD   = 2'b11;
  localparam logic [1:0] C_TAG_PLAIN  = 2'b01;
  localparam logic [1:0] C_TAG_CIPHER = 2'b10;

  localparam int              GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]   C_GAP = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]   C_ONE = GW'(1);

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic [MESSAGE_SIZE-1:0] r_enc;
  logic                    r_mixed;
  logic [GW-1:0]           r_gap_cnt;

  logic                    w_accept;
  logic                    w_legal;
  logic                    w_start;
  logic                    w_handshake;
  logic                    w_valid;
  logic                    w_ready;
  logic                    w_err;
  logic [MESSAGE_SIZE-1:0] w_msg;
  logic [HEADER_SIZE-1:0]  w_hdr;
  logic [GW-1:0]           w_gap;

  assign w_accept    = ext_tx_valid_in && ext_tx_ready_out;
  assign w_legal     = (tx_mode_in != C_MODE_BAD);
  assign w_start     = (r_state == S_IDLE) && w_accept && w_legal;
  assign w_handshake = bdge_valid_out && bdge_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_FIRST;
      end
      S_FIRST: begin
        if (w_handshake) begin
          if (!r_mixed)            w_next = S_IDLE;
          else if (GAP_CYCLES > 0) w_next = S_GAP;
          else                     w_next = S_SECOND;
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= C_ONE) w_next = S_SECOND;
      end
      S_SECOND: begin
        if (w_handshake) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered: compute their next values from the next state.
  always_comb begin
    w_valid = (w_next == S_FIRST) || (w_next == S_SECOND);
    w_ready = (w_next == S_IDLE);
    w_err   = (r_state == S_IDLE) && w_accept && !w_legal;
    w_msg   = bdge_message_out;
    w_hdr   = bdge_header_out;
    w_gap   = r_gap_cnt;
    if (w_start) begin
      w_msg      = (tx_mode_in == C_MODE_ENC) ? tx_encrypted_in : tx_decrypted_in;
      w_hdr      = tx_header_in;
      w_hdr[1:0] = (tx_mode_in == C_MODE_ENC) ? C_TAG_CIPHER : C_TAG_PLAIN;
    end else if ((r_state == S_FIRST) && w_handshake && r_mixed) begin
      w_msg      = r_enc;
      w_hdr[1:0] = C_TAG_CIPHER;
      w_gap      = C_GAP;
    end
    if (r_state == S_GAP) w_gap = r_gap_cnt - C_ONE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ext_tx_ready_out <= 1'b1;
      bdge_valid_out   <= 1'b0;
      bdge_message_out <= '0;
      bdge_header_out  <= '0;
      mode_err_out     <= 1'b0;
      frames_sent_out  <= 16'd0;
      r_gap_cnt        <= '0;
      r_enc            <= '0;
      r_mixed          <= 1'b0;
    end else begin
      ext_tx_ready_out <= w_ready;
      bdge_valid_out   <= w_valid;
      bdge_message_out <= w_msg;
      bdge_header_out  <= w_hdr;
      mode_err_out     <= w_err;
      frames_sent_out  <= frames_sent_out + {15'd0, w_handshake};
      r_gap_cnt        <= w_gap;
      if (w_start) begin
        r_enc   <= tx_encrypted_in;
        r_mixed <= (tx_mode_in == C_MODE_MIXED);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// Directed bench for uart_tx_scheduler: RAW, MIXED gap, ENC backpressure, illegal mode,
// mid-job reset and counter wrap with back-to-back jobs.
module tb_uart_tx_scheduler;

  localparam int MS = 512;
  localparam int HS = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          ext_tx_valid_in;
  logic          ext_tx_ready_out;
  logic [MS-1:0] tx_encrypted_in;
  logic [MS-1:0] tx_decrypted_in;
  logic [HS-1:0] tx_header_in;
  logic [1:0]    tx_mode_in;
  logic [MS-1:0] bdge_message_out;
  logic [HS-1:0] bdge_header_out;
  logic          bdge_valid_out;
  logic          bdge_ready_in;
  logic          mode_err_out;
  logic [15:0]   frames_sent_out;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_scheduler #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS), .GAP_CYCLES(16)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .ext_tx_valid_in  (ext_tx_valid_in),
    .ext_tx_ready_out (ext_tx_ready_out),
    .tx_encrypted_in  (tx_encrypted_in),
    .tx_decrypted_in  (tx_decrypted_in),
    .tx_header_in     (tx_header_in),
    .tx_mode_in       (tx_mode_in),
    .bdge_message_out (bdge_message_out),
    .bdge_header_out  (bdge_header_out),
    .bdge_valid_out   (bdge_valid_out),
    .bdge_ready_in    (bdge_ready_in),
    .mode_err_out     (mode_err_out),
    .frames_sent_out  (frames_sent_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [MS-1:0] obs, input logic [MS-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] mode, input logic [HS-1:0] hdr,
                       input logic [MS-1:0] dec, input logic [MS-1:0] enc);
    tx_mode_in      = mode;
    tx_header_in    = hdr;
    tx_decrypted_in = dec;
    tx_encrypted_in = enc;
    ext_tx_valid_in = 1'b1;
  endtask

  logic [MS-1:0] d1, e1, d2, e2, e3, d4, e4, d5;
  logic [MS-1:0] snap_msg;
  logic [HS-1:0] snap_hdr;
  int            cnt;
  int            bad;

  initial begin
    d1 = {16{32'hD1D1_0001}}; e1 = {16{32'hE1E1_0001}};
    d2 = {16{32'hD2D2_0002}}; e2 = {16{32'hE2E2_0002}};
    e3 = {16{32'hE3E3_0003}};
    d4 = {16{32'hD4D4_0004}}; e4 = {16{32'hE4E4_0004}};
    d5 = {16{32'hD5D5_0005}};

    rst_in = 1'b0; ext_tx_valid_in = 1'b0; bdge_ready_in = 1'b0;
    tx_mode_in = 2'b00; tx_header_in = '0; tx_decrypted_in = '0; tx_encrypted_in = '0;
    step(); step();
    chk("rst_ready", MS'(ext_tx_ready_out), MS'(1'b1));
    chk("rst_valid", MS'(bdge_valid_out), '0);
    chk("rst_msg", bdge_message_out, '0);
    chk("rst_hdr", MS'(bdge_header_out), '0);
    chk("rst_err", MS'(mode_err_out), '0);
    chk("rst_frames", MS'(frames_sent_out), '0);
    rst_in = 1'b1;

    // RAW job, bridge always ready
    bdge_ready_in = 1'b1;
    offer(2'b01, 32'hA5A5_0000, d1, e1);
    step();
    ext_tx_valid_in = 1'b0;
    chk("raw_valid", MS'(bdge_valid_out), MS'(1'b1));
    chk("raw_msg", bdge_message_out, d1);
    chk("raw_hdr", MS'(bdge_header_out), MS'(32'hA5A5_0001));
    chk("raw_busy", MS'(ext_tx_ready_out), '0);
    step();
    chk("raw_done_valid", MS'(bdge_valid_out), '0);
    chk("raw_done_ready", MS'(ext_tx_ready_out), MS'(1'b1));
    chk("raw_frames", MS'(frames_sent_out), MS'(16'd1));

    // MIXED job with 16-cycle gap
    offer(2'b00, 32'h1234_5677, d2, e2);
    step();
    ext_tx_valid_in = 1'b0;
    chk("mix1_msg", bdge_message_out, d2);
    chk("mix1_hdr", MS'(bdge_header_out), MS'(32'h1234_5675));
    step();
    cnt = 0;
    while (!bdge_valid_out && cnt < 40) begin
      cnt++;
      step();
    end
    chk("mix_gap_len", MS'(cnt), MS'(16));
    chk("mix2_msg", bdge_message_out, e2);
    chk("mix2_hdr", MS'(bdge_header_out), MS'(32'h1234_5676));
    step();
    chk("mix_done_valid", MS'(bdge_valid_out), '0);
    chk("mix_done_ready", MS'(ext_tx_ready_out), MS'(1'b1));
    chk("mix_frames", MS'(frames_sent_out), MS'(16'd3));

    // ENC job held off by the bridge for 50 cycles
    bdge_ready_in = 1'b0;
    offer(2'b10, 32'hCAFE_F00C, d1, e3);
    step();
    ext_tx_valid_in = 1'b0;
    snap_msg = bdge_message_out;
    snap_hdr = bdge_header_out;
    chk("enc_msg", snap_msg, e3);
    chk("enc_hdr", MS'(snap_hdr), MS'(32'hCAFE_F00E));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!bdge_valid_out || bdge_message_out !== e3 || bdge_header_out !== 32'hCAFE_F00E)
        bad++;
      step();
    end
    chk("enc_hold", MS'(bad), '0);
    chk("enc_frames_wait", MS'(frames_sent_out), MS'(16'd3));
    bdge_ready_in = 1'b1;
    step();
    chk("enc_done_valid", MS'(bdge_valid_out), '0);
    chk("enc_frames", MS'(frames_sent_out), MS'(16'd4));

    // illegal mode
    offer(2'b11, 32'h0BAD_0000, d1, e1);
    step();
    ext_tx_valid_in = 1'b0;
    chk("bad_err", MS'(mode_err_out), MS'(1'b1));
    chk("bad_valid", MS'(bdge_valid_out), '0);
    chk("bad_ready", MS'(ext_tx_ready_out), MS'(1'b1));
    step();
    chk("bad_err_pulse", MS'(mode_err_out), '0);
    chk("bad_valid2", MS'(bdge_valid_out), '0);
    chk("bad_frames", MS'(frames_sent_out), MS'(16'd4));

    // reset in the middle of a MIXED gap
    offer(2'b00, 32'h7777_0000, d4, e4);
    step();
    ext_tx_valid_in = 1'b0;
    step(); step(); step(); step();
    rst_in = 1'b0;
    #1;
    chk("mrst_valid", MS'(bdge_valid_out), '0);
    chk("mrst_ready", MS'(ext_tx_ready_out), MS'(1'b1));
    chk("mrst_msg", bdge_message_out, '0);
    chk("mrst_frames", MS'(frames_sent_out), '0);
    step(); step();
    rst_in = 1'b1;
    offer(2'b01, 32'h5555_0000, d5, e1);
    step();
    ext_tx_valid_in = 1'b0;
    chk("post_msg", bdge_message_out, d5);
    chk("post_hdr", MS'(bdge_header_out), MS'(32'h5555_0001));
    step();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (bdge_valid_out || bdge_message_out === e4) bad++;
      step();
    end
    chk("no_stale_frame", MS'(bad), '0);
    chk("post_frames", MS'(frames_sent_out), MS'(16'd1));

    // counter preload, then 17 back-to-back RAW jobs: 16'hFFF0 + 17 wraps to 1
    force dut.frames_sent_out = 16'hFFF0;
    #2;
    release dut.frames_sent_out;
    offer(2'b01, 32'h0000_0100, d1, e1);
    step();
    bad = 0;
    for (int j = 0; j < 17; j++) begin
      if (!bdge_valid_out || ext_tx_ready_out) bad++;
      step();
      if (bdge_valid_out || !ext_tx_ready_out) bad++;
      if (j == 16) ext_tx_valid_in = 1'b0;
      else step();
    end
    chk("b2b_timing", MS'(bad), '0);
    chk("wrap_frames", MS'(frames_sent_out), MS'(16'd1));
    step();
    chk("wrap_idle", MS'(bdge_valid_out), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
